conbus_arb_rr: RTL and testbench

- N-way round-robin bus-ownership arbiter for the conbus interconnect.
- Grants one master at a time; the owner keeps the bus until it drops its request (cycle-hold semantics).
- On release, ownership rotates fairly to the next requester.
- Drives the conbus master-side muxes and the slave-select qualification.

---
 rtl/conbus_pkg.sv | 25 ++
 rtl/conbus_rr_pick.sv | 33 +++
 rtl/conbus_arb_rr.sv | 158 +++++++++++++++
 tb/tb_conbus_arb_rr.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/conbus_pkg.sv
// Shared definitions for the conbus round-robin arbiter: state encoding,
// default sizing constants and a log2 helper for parameter checks.
package conbus_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    localparam int unsigned CONBUS_N_REQ  = 4;
    localparam int unsigned CONBUS_QUOTA  = 64;
    localparam int unsigned CONBUS_CNT_W  = 16;

    function automatic int unsigned conbus_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/conbus_rr_pick.sv
// Combinational round-robin search: first set request bit found scanning
// base+1, base+2, ... with wrap; base itself is considered last.
module conbus_rr_pick
    import conbus_pkg::*;
#(
    parameter int unsigned N_REQ = CONBUS_N_REQ,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] base_i,
    output logic             found_o,
    output logic [N_REQ-1:0] pick_oh_o,
    output logic [IDX_W-1:0] pick_idx_o
);

    int unsigned cand;

    always_comb begin
        found_o    = 1'b0;
        pick_oh_o  = '0;
        pick_idx_o = '0;
        cand       = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(base_i) + k) % N_REQ;
            if (!found_o && req_i[cand[IDX_W-1:0]]) begin
                found_o                       = 1'b1;
                pick_oh_o[cand[IDX_W-1:0]]    = 1'b1;
                pick_idx_o                    = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/conbus_arb_rr.sv
// N-way round-robin bus-ownership arbiter with cycle-hold semantics.
// Optional forced rotation after QUOTA owned cycles: define CONBUS_ARB_QUOTA_EN.
module conbus_arb_rr
    import conbus_pkg::*;
#(
    parameter int unsigned N_REQ = CONBUS_N_REQ,
    parameter int unsigned IDX_W = 2,
    parameter int unsigned QUOTA = CONBUS_QUOTA
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             rearb,
    output logic             preempt
);

    if (IDX_W != conbus_clog2(N_REQ)) begin : g_chk_idx_w
        $error("conbus_arb_rr: IDX_W must equal clog2(N_REQ)");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_chk_n_req
        $error("conbus_arb_rr: N_REQ out of range 2..8");
    end
    if (QUOTA < 2 || QUOTA > 65535) begin : g_chk_quota
        $error("conbus_arb_rr: QUOTA out of range 2..65535");
    end

    localparam logic [IDX_W-1:0] IDX_RST = IDX_W'(N_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             rearb_q, rearb_d;

`ifdef CONBUS_ARB_QUOTA_EN
    localparam logic [CONBUS_CNT_W-1:0] CNT_MAX = CONBUS_CNT_W'(QUOTA - 1);
    logic [CONBUS_CNT_W-1:0] cnt_q, cnt_d;
    logic                    preempt_q, preempt_d;
`endif

    logic [N_REQ-1:0] avail;
    logic             pick_found;
    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             owner_req;

    // gnt_idx always holds the most recent owner, so it doubles as the
    // round-robin base; masking the owner keeps a preempted owner from
    // re-winning its own rotation.
    assign avail     = req_q & ~gnt_q;
    assign owner_req = req_q[gnt_idx_q];

    conbus_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i      (avail),
        .base_i     (gnt_idx_q),
        .found_o    (pick_found),
        .pick_oh_o  (pick_oh),
        .pick_idx_o (pick_idx)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ARB_IDLE;
            req_q     <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= IDX_RST;
            rearb_q   <= 1'b0;
`ifdef CONBUS_ARB_QUOTA_EN
            cnt_q     <= '0;
            preempt_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            rearb_q   <= rearb_d;
`ifdef CONBUS_ARB_QUOTA_EN
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        rearb_d   = 1'b0;
`ifdef CONBUS_ARB_QUOTA_EN
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d   = ARB_HOLD;
                    gnt_d     = pick_oh;
                    gnt_idx_d = pick_idx;
                    rearb_d   = 1'b1;
`ifdef CONBUS_ARB_QUOTA_EN
                    cnt_d     = '0;
`endif
                end
            end
            ARB_HOLD: begin
                if (!owner_req) begin
                    if (pick_found) begin
                        gnt_d     = pick_oh;
                        gnt_idx_d = pick_idx;
                        rearb_d   = 1'b1;
`ifdef CONBUS_ARB_QUOTA_EN
                        cnt_d     = '0;
`endif
                    end else begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                    end
                end else begin
`ifdef CONBUS_ARB_QUOTA_EN
                    if (cnt_q == CNT_MAX && pick_found) begin
                        gnt_d     = pick_oh;
                        gnt_idx_d = pick_idx;
                        rearb_d   = 1'b1;
                        preempt_d = 1'b1;
                        cnt_d     = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        gnt       = gnt_q;
        gnt_idx   = gnt_idx_q;
        gnt_valid = |gnt_q;
        rearb     = rearb_q;
`ifdef CONBUS_ARB_QUOTA_EN
        preempt   = preempt_q;
`else
        preempt   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_conbus_arb_rr.sv
// Self-checking bench for conbus_arb_rr: directed scenarios followed by random
// request traffic, all compared against a behavioural round-robin model.
module tb_conbus_arb_rr;

    localparam int NR = 4;
    localparam int QT = 4;

    logic          sys_clk;
    logic          sys_rst_n;
    logic [NR-1:0] req;
    logic [NR-1:0] gnt;
    logic [1:0]    gnt_idx;
    logic          gnt_valid;
    logic          rearb;
    logic          preempt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_owner;
    int          m_idx;
    int          m_cnt;
    bit [NR-1:0] m_reqq;
    bit          m_rearb;
    bit          m_preempt;

    conbus_arb_rr #(
        .N_REQ (NR),
        .IDX_W (2),
        .QUOTA (QT)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .rearb     (rearb),
        .preempt   (preempt)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic int rr_next(input bit [NR-1:0] r, input int from);
        for (int k = 1; k <= NR; k++) begin
            if (r[(from + k) % NR]) return (from + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_idx     = NR - 1;
        m_cnt     = 0;
        m_reqq    = '0;
        m_rearb   = 0;
        m_preempt = 0;
    endtask

    task automatic model_grant(input int c);
        m_owner = c;
        m_idx   = c;
        m_rearb = 1;
        m_cnt   = 0;
    endtask

    // One rising edge: the arbiter acts on requests registered at the previous edge.
    task automatic model_edge(input bit [NR-1:0] r);
        bit [NR-1:0] others;
        int c;
        m_rearb   = 0;
        m_preempt = 0;
        if (m_owner < 0) begin
            c = rr_next(m_reqq, m_idx);
            if (c >= 0) model_grant(c);
        end else if (!m_reqq[m_owner]) begin
            c = rr_next(m_reqq, m_owner);
            if (c >= 0) model_grant(c);
            else m_owner = -1;
        end else begin
            others = m_reqq;
            others[m_owner] = 1'b0;
`ifdef CONBUS_ARB_QUOTA_EN
            if (m_cnt == QT - 1 && others != 0) begin
                model_grant(rr_next(others, m_owner));
                m_preempt = 1;
            end else if (m_cnt < QT - 1) begin
                m_cnt++;
            end
`endif
        end
        m_reqq = r;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [NR-1:0] eg;
        eg = (m_owner < 0) ? '0 : (NR'(1) << m_owner);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("gnt_idx", 32'(gnt_idx), 32'(m_idx));
        chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        chk("rearb", 32'(rearb), 32'(m_rearb));
        chk("preempt", 32'(preempt), 32'(m_preempt));
    endtask

    task automatic step(input logic [NR-1:0] r);
        req = r;
        @(posedge sys_clk);
        model_edge(r);
        #1;
        check_all();
    endtask

    task automatic steps(input logic [NR-1:0] r, input int n);
        for (int i = 0; i < n; i++) step(r);
    endtask

    // Entered 1ns after a rising edge; reset is asserted and released mid-cycle.
    task automatic do_reset();
        #3;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        check_all();
        #2;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        logic [NR-1:0] r;
        sys_rst_n = 1'b0;
        req       = '0;
        model_reset();
        #7;
        check_all();
        #1;
        sys_rst_n = 1'b1;

        // All requesting from reset: master 0 first, then direct hand-over.
        steps(4'b1111, 3);
        steps(4'b1110, 2);
        steps(4'b1101, 3);
        // Owner 2 held against full contention.
        steps(4'b1111, 20);
        // Lone master 3 with a one-cycle release.
        steps(4'b1000, 3);
        step(4'b0000);
        steps(4'b1000, 3);
        // Owner 3 releases, then 0 and 2 arrive together: wrap to 0.
        steps(4'b0000, 2);
        steps(4'b0101, 3);
        steps(4'b0100, 3);
        steps(4'b0000, 2);
        // Two masters contending for a long time, then a single one.
        steps(4'b0011, 14);
        steps(4'b0001, 10);
        // Get master 2 onto the bus, then reset mid-ownership.
        steps(4'b0100, 3);
        do_reset();
        steps(4'b0100, 3);
        steps(4'b0000, 2);

        // Random traffic with sticky requests so ownership lasts several cycles.
        r = '0;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < NR; b++) begin
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            step(r);
            if (i == 200) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
